msd_cmd_issuer: RTL

//  Downstream of the 16-entry memory-controller request queue: pops one 38-bit request at a time
//  ({op[37:36], addr[35:0]}) and emits the DDR5 command sequence ACT0,ACT1,RD0/WR0,RD1/WR1,PRE
//  on a registered command bus, enforcing tRCD/tRTP/tWR/tRP spacing. Closed-page policy, one

---
 rtl/msd_pkg.sv | 35 +++
 rtl/msd_timer.sv | 26 ++
 rtl/msd_cmd_issuer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/msd_pkg.sv
// Shared types for the memory-controller issue path: DDR5 command encoding,
// request opcodes, address field positions and the queue entry layout.
package msd_pkg;

  typedef enum logic [2:0] {
    CMD_ACT0 = 3'd0,
    CMD_ACT1 = 3'd1,
    CMD_RD0  = 3'd2,
    CMD_RD1  = 3'd3,
    CMD_WR0  = 3'd4,
    CMD_WR1  = 3'd5,
    CMD_PRE  = 3'd6
  } cmd_e;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_IF  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  localparam int unsigned CH_BIT  = 6;
  localparam int unsigned BG_MSB  = 9;
  localparam int unsigned BG_LSB  = 7;
  localparam int unsigned BA_MSB  = 11;
  localparam int unsigned BA_LSB  = 10;
  localparam int unsigned COL_MSB = 17;
  localparam int unsigned COL_LSB = 12;
  localparam int unsigned ROW_MSB = 33;
  localparam int unsigned ROW_LSB = 18;

  typedef struct packed {
    logic [1:0]  op;
    logic [35:0] addr;
  } req_t;

endpackage

// File: rtl/msd_timer.sv
// Loadable down counter used to space DDR commands; saturates at zero.
module msd_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/msd_cmd_issuer.sv
// Pops one request from the controller queue and issues the closed-page
// DDR5 sequence ACT0, ACT1, RD/WR pair, PRE with tRCD/tRTP/tWR/tRP spacing.
module msd_cmd_issuer
  import msd_pkg::*;
#(
  parameter int unsigned T_RCD    = 39,
  parameter int unsigned T_RTP    = 18,
  parameter int unsigned T_WR2PRE = 70,
  parameter int unsigned T_RP     = 39,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [37:0] req_data,
  output logic        req_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic        cmd_ch,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [15:0] cmd_row,
  output logic [5:0]  cmd_col,
  output logic        req_done,
  output logic        err_illegal
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ACT0     = 4'd1;
  localparam logic [3:0] S_ACT1     = 4'd2;
  localparam logic [3:0] S_WAIT_RCD = 4'd3;
  localparam logic [3:0] S_CAS0     = 4'd4;
  localparam logic [3:0] S_CAS1     = 4'd5;
  localparam logic [3:0] S_WAIT_PRE = 4'd6;
  localparam logic [3:0] S_PRE      = 4'd7;
  localparam logic [3:0] S_WAIT_RP  = 4'd8;

  req_t        req;
  logic        accept, known_op;
  logic [3:0]  state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        cmd_valid_q, cmd_valid_d;
  cmd_e        cmd_q, cmd_d;
  logic        req_done_q, req_done_d;
  logic        err_q, err_d;
  logic        wr_q;
  logic        ch_q;
  logic [2:0]  bg_q;
  logic [1:0]  ba_q;
  logic [15:0] row_q;
  logic [5:0]  col_q;
  logic        t_load, t_zero;
  logic [CNT_W-1:0] t_value;
  logic        unused_addr_bits;

  assign req              = req_data;
  assign accept           = req_valid && req_ready_q;
  assign known_op         = req.op inside {OP_RD, OP_IF, OP_WR};
  assign unused_addr_bits = ^{req.addr[35:34], req.addr[5:0]};

  msd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (t_load),
    .value_i (t_value),
    .zero_o  (t_zero)
  );

  // ACT1/CAS1 test the timer directly so the minimum spacing of 2 skips the wait state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:                 if (accept && known_op) state_d = S_ACT0;
      S_ACT0:                 state_d = S_ACT1;
      S_ACT1, S_WAIT_RCD:     state_d = t_zero ? S_CAS0 : S_WAIT_RCD;
      S_CAS0:                 state_d = S_CAS1;
      S_CAS1, S_WAIT_PRE:     state_d = t_zero ? S_PRE : S_WAIT_PRE;
      S_PRE:                  state_d = S_WAIT_RP;
      S_WAIT_RP:              state_d = t_zero ? S_IDLE : S_WAIT_RP;
      default:                state_d = S_IDLE;
    endcase
  end

  // Load delay-1 on entry to each issuing command so the follow-up lands exactly on time.
  always_comb begin
    t_load  = 1'b0;
    t_value = '0;
    case (state_d)
      S_ACT0: begin
        t_load  = 1'b1;
        t_value = CNT_W'(T_RCD - 1);
      end
      S_CAS0: begin
        t_load  = 1'b1;
        t_value = wr_q ? CNT_W'(T_WR2PRE - 1) : CNT_W'(T_RTP - 1);
      end
      S_PRE: begin
        t_load  = 1'b1;
        t_value = CNT_W'(T_RP - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready_d = (state_d == S_IDLE) && !accept;
    cmd_valid_d = state_d inside {S_ACT0, S_ACT1, S_CAS0, S_CAS1, S_PRE};
    req_done_d  = (state_d == S_PRE);
    err_d       = accept && !known_op;
    cmd_d       = cmd_q;
    case (state_d)
      S_ACT0:  cmd_d = CMD_ACT0;
      S_ACT1:  cmd_d = CMD_ACT1;
      S_CAS0:  cmd_d = wr_q ? CMD_WR0 : CMD_RD0;
      S_CAS1:  cmd_d = wr_q ? CMD_WR1 : CMD_RD1;
      S_PRE:   cmd_d = CMD_PRE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_ACT0;
      req_done_q  <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      ch_q        <= 1'b0;
      bg_q        <= '0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      req_done_q  <= req_done_d;
      err_q       <= err_d;
      if (accept) begin
        wr_q  <= (req.op == OP_WR);
        ch_q  <= req.addr[CH_BIT];
        bg_q  <= req.addr[BG_MSB:BG_LSB];
        ba_q  <= req.addr[BA_MSB:BA_LSB];
        row_q <= req.addr[ROW_MSB:ROW_LSB];
        col_q <= req.addr[COL_MSB:COL_LSB];
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;
  assign cmd_ch      = ch_q;
  assign cmd_bg      = bg_q;
  assign cmd_ba      = ba_q;
  assign cmd_row     = row_q;
  assign cmd_col     = col_q;
  assign req_done    = req_done_q;
  assign err_illegal = err_q;

endmodule
